ps2_keymap_decoder: RTL and testbench
=====================================

Name: ps2_keymap_decoder

Overview:
- Parametrised successor to the inline arrow/select make-break decoder in the tile game top level.
- Consumes the PS2_Controller byte stream (received_data / received_data_en) and decodes the full scan-code set-2 grammar: E0 extended prefix, F0 break prefix, E1 pause sequence.
- Maps NUM_KEYS configurable codes to held levels, press/release pulses and a software auto-repeat.
- Sits in the CLOCK_50 domain; its outputs feed the pixelClk synchronisers ahead of ingameFSM.

Parameters:
- NUM_KEYS, 5, number of mapped keys; index 0..NUM_KEYS-1.
- KEYCODES, {8'h29,8'h74,8'h6B,8'h72,8'h75}, packed 8*NUM_KEYS scan codes, key i at bits [8i+7:8i]; default order is 0=up, 1=down, 2=left, 3=right, 4=space/select.
- EXT_MASK, 5'b01111, bit i=1 means key i requires the E0 prefix.
- REPEAT_DELAY, 25_000_000, cycles from the initial press to the first repeat pulse; 0 disables auto-repeat.
- REPEAT_RATE, 5_000_000, cycles between subsequent repeat pulses; must be at least 1.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- received_data  in  8  byte from PS2_Controller.
- received_data_en  in  1  one-cycle strobe; received_data is valid in this cycle.
- key_held  out  NUM_KEYS  level; key i is currently down.
- key_press  out  NUM_KEYS  one-cycle pulse on the initial make or an auto-repeat.
- key_release  out  NUM_KEYS  one-cycle pulse on break.
- any_held  out  1  OR of key_held.
- unmapped  out  1  one-cycle pulse when a complete make sequence matches no key.

Behaviour:
- Single clock, CLOCK_50. Reset is synchronous and active-high.
- Reset: all outputs 0; parser in IDLE; repeat engine idle; skip counter 0.
- All outputs are registered. Each is valid the cycle after the received_data_en carrying the sequence's final byte.
- Bytes are only processed in cycles where received_data_en=1.
- Parser states:
  - IDLE: E0 -> EXT. F0 -> BRK. E1 -> SKIP with count=7. Bytes AA, FA, FE, EE, 00, FF are ignored and the state stays IDLE. Any other byte is a make with ext=0, then back to IDLE.
  - EXT: F0 -> EXT_BRK. Any other byte is a make with ext=1 -> IDLE.
  - BRK: any byte is a break with ext=0 -> IDLE.
  - EXT_BRK: any byte is a break with ext=1 -> IDLE.
  - SKIP: decrement count on each byte; at count 1, return to IDLE. No outputs during the sequence.
- Match rule: key i matches when code==KEYCODES[i] and ext==EXT_MASK[i]. All matching indices respond.
- Make on a matching key:
  - Key not held: set key_held[i] and pulse key_press[i].
  - Key already held (typematic resend): no pulse, no state change.
- Make on no matching key: pulse unmapped; nothing else changes.
- Break on a matching key: clear key_held[i] and pulse key_release[i], but only if the key was held.
- Break on no matching key: ignored, no pulse.
- Auto-repeat engine (active only when REPEAT_DELAY>0):
  - Tracks one key, rpt_idx: the key most recently press-pulsed from a make.
  - On that make: counter=0, phase=DELAY.
  - Each cycle while key_held[rpt_idx]=1: counter increments.
  - In DELAY, at counter==REPEAT_DELAY-1: pulse key_press[rpt_idx], counter=0, phase=RATE.
  - In RATE, at counter==REPEAT_RATE-1: pulse key_press[rpt_idx], counter=0.
  - Counter width is $clog2 of the larger of REPEAT_DELAY and REPEAT_RATE; it never wraps.
- Repeat boundary conditions:
  - Break of rpt_idx: engine goes idle. No repeat pulse that cycle or after.
  - Break of any other key: engine is unaffected.
  - A make event and a repeat expiry in the same cycle: the make event wins. The new key pulses, the engine retargets and reloads, and the old key's expiry pulse is dropped.
- Reset asserted mid-sequence (e.g. after E0, or inside SKIP): returns to IDLE; all keys are released without release pulses.
- Prefix followed by a prefix: E0 E0 treats the second E0 as a make code (unmapped by default). F0 F0 treats the second F0 as a break code (ignored).

Test Plan:
- Bytes E0,75 -> key_held[0]=1 and key_press=5'b00001 for exactly 1 cycle, the cycle after the second strobe. Then E0,F0,75 -> key_release=5'b00001 pulse and key_held[0]=0.
- Byte 75 with no prefix (keypad 8) -> no key_held change; unmapped pulses once. Bytes 29 then F0,29 -> select (key 4) press pulse, then release pulse.
- REPEAT_DELAY=20, REPEAT_RATE=5; send E0,72 and hold -> press pulses at +1, +21, +26, +31 cycles after the strobe. Resend E0,72 at cycle 23 -> no extra pulse, and the repeat schedule is unchanged.
- Hold up (E0,75), then press left (E0,6B) -> repeats move to key 2 only. Send E0,F0,75 -> key_release[0] pulse, key 2 keeps repeating. Put a make and a repeat expiry in the same cycle -> only the make pulse appears.
- Bytes E1,14,77,E1,F0,14,F0,77, then E0,74 -> no outputs for the first 8 bytes; right (key 3) press follows. Bytes AA and FA in IDLE -> no outputs.
- Send E0, then assert reset for 1 cycle, then send 75 -> parser is in IDLE, so unmapped pulses and key_held=0. Assert reset while key 1 is held -> key_held=0 with no release pulse.

Source files
------------

// File: rtl/ps2_keymap_decoder.sv
// ps2_keymap_decoder
//
// Decodes the scan-code set-2 byte stream from PS2_Controller into per-key
// held levels, press/release pulses and a software auto-repeat. Handles the
// E0 (extended), F0 (break) and E1 (pause, eight bytes) sequences. Lives in
// the CLOCK_50 domain; every output is registered and is valid the cycle
// after the strobe that carries a sequence's final byte.
//
// Input handshake: received_data is sampled only in cycles where
// received_data_en is 1. There is no ready/back-pressure, so every strobed
// byte is consumed in the cycle it arrives.
//
// Ports:
//   CLOCK_50          in   system clock
//   reset             in   synchronous, active-high reset
//   received_data     in   [7:0] byte from PS2_Controller
//   received_data_en  in   one-cycle strobe qualifying received_data
//   key_held          out  [NUM_KEYS-1:0] level, key i is down
//   key_press         out  [NUM_KEYS-1:0] pulse on first make or auto-repeat
//   key_release       out  [NUM_KEYS-1:0] pulse on break of a held key
//   any_held          out  OR of key_held
//   unmapped          out  pulse when a complete make matches no key
module ps2_keymap_decoder #(
    parameter int                      NUM_KEYS     = 5,
    parameter logic [8*NUM_KEYS-1:0]   KEYCODES     = {8'h29, 8'h74, 8'h6B, 8'h72, 8'h75},
    parameter logic [NUM_KEYS-1:0]     EXT_MASK     = 5'b01111,
    parameter int                      REPEAT_DELAY = 25_000_000,
    parameter int                      REPEAT_RATE  = 5_000_000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_held,
    output logic                unmapped
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam bit RPT_EN  = (REPEAT_DELAY > 0);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } parseState_t;

    parseState_t         parseState;
    logic [2:0]          skipCnt;

    // Auto-repeat engine: one tracked key, a shared counter, and a phase bit
    // selecting the initial delay or the steady repeat interval.
    logic                rptActive;
    logic                rptInRate;
    logic [CNT_W-1:0]    rptCnt;
    logic [IDX_W-1:0]    rptIdx;

    logic                makeEv;
    logic                breakEv;
    logic                evExt;
    logic [NUM_KEYS-1:0] matchVec;
    logic [NUM_KEYS-1:0] newPress;
    logic [NUM_KEYS-1:0] newRelease;
    logic [NUM_KEYS-1:0] heldNext;
    logic [NUM_KEYS-1:0] rptMask;
    logic [NUM_KEYS-1:0] repeatMask;
    logic [IDX_W-1:0]    firstIdx;
    logic                noMatch;
    logic                killRpt;
    logic                retarget;
    logic                rptFire;

    // Controller acknowledgements, self-test results and error bytes that
    // carry no key information when seen outside a prefix.
    function automatic logic isFiller(input logic [7:0] b);
        return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    always_comb begin
        makeEv     = 1'b0;
        breakEv    = 1'b0;
        evExt      = 1'b0;
        matchVec   = '0;
        firstIdx   = '0;
        rptMask    = '0;

        if (received_data_en) begin
            unique case (parseState)
                ST_IDLE: makeEv = !(received_data inside {8'hE0, 8'hF0, 8'hE1})
                                  && !isFiller(received_data);
                ST_EXT: begin
                    makeEv = (received_data != 8'hF0);
                    evExt  = 1'b1;
                end
                ST_BRK: breakEv = 1'b1;
                ST_EXT_BRK: begin
                    breakEv = 1'b1;
                    evExt   = 1'b1;
                end
                default: ;
            endcase
        end

        for (int i = 0; i < NUM_KEYS; i++) begin
            matchVec[i] = (received_data == KEYCODES[8*i +: 8]) && (evExt == EXT_MASK[i]);
            rptMask[i]  = (rptIdx == IDX_W'(i));
        end

        // A resend of an already-held key is typematic noise: no pulse.
        newPress   = makeEv  ? (matchVec & ~key_held) : '0;
        newRelease = breakEv ? (matchVec &  key_held) : '0;
        noMatch    = makeEv && (matchVec == '0);
        heldNext   = (key_held | newPress) & ~newRelease;

        // Lowest newly pressed index becomes the repeat target.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (newPress[i]) firstIdx = IDX_W'(i);
        end

        killRpt  = |(newRelease & rptMask);
        retarget = RPT_EN && (newPress != '0);
        rptFire  = RPT_EN && rptActive &&
                   (rptInRate ? (rptCnt == RATE_LAST) : (rptCnt == DELAY_LAST));

        // A fresh make takes priority over an expiry landing in the same cycle,
        // and a break of the tracked key suppresses its expiry.
        repeatMask = (rptFire && !retarget && !killRpt) ? rptMask : '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            parseState  <= ST_IDLE;
            skipCnt     <= '0;
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            any_held    <= 1'b0;
            unmapped    <= 1'b0;
            rptActive   <= 1'b0;
            rptInRate   <= 1'b0;
            rptCnt      <= '0;
            rptIdx      <= '0;
        end else begin
            if (received_data_en) begin
                unique case (parseState)
                    ST_IDLE: begin
                        if (received_data == 8'hE0) begin
                            parseState <= ST_EXT;
                        end else if (received_data == 8'hF0) begin
                            parseState <= ST_BRK;
                        end else if (received_data == 8'hE1) begin
                            // Pause key: E1 plus seven more bytes, none decoded.
                            parseState <= ST_SKIP;
                            skipCnt    <= 3'd7;
                        end
                    end
                    ST_EXT:     parseState <= (received_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                    ST_BRK:     parseState <= ST_IDLE;
                    ST_EXT_BRK: parseState <= ST_IDLE;
                    ST_SKIP: begin
                        if (skipCnt == 3'd1) parseState <= ST_IDLE;
                        skipCnt <= skipCnt - 3'd1;
                    end
                    default:    parseState <= ST_IDLE;
                endcase
            end

            key_held    <= heldNext;
            key_press   <= newPress | repeatMask;
            key_release <= newRelease;
            any_held    <= |heldNext;
            unmapped    <= noMatch;

            if (retarget) begin
                rptActive <= 1'b1;
                rptInRate <= 1'b0;
                rptCnt    <= '0;
                rptIdx    <= firstIdx;
            end else if (killRpt) begin
                rptActive <= 1'b0;
                rptInRate <= 1'b0;
                rptCnt    <= '0;
            end else if (rptActive) begin
                if (rptFire) begin
                    rptInRate <= 1'b1;
                    rptCnt    <= '0;
                end else begin
                    rptCnt <= rptCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Bench for ps2_keymap_decoder with REPEAT_DELAY=20, REPEAT_RATE=5.
// A sequence-level reference model (byte queue + absolute repeat deadlines)
// is stepped every cycle; table vectors and hand sequences add fixed checks.
module tb_ps2_keymap_decoder;

    localparam int NK = 5;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    received_data = 8'h00;
    logic          received_data_en = 1'b0;
    logic [NK-1:0] key_held;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic          any_held;
    logic          unmapped;

    ps2_keymap_decoder #(
        .NUM_KEYS    (NK),
        .KEYCODES    ({8'h29, 8'h74, 8'h6B, 8'h72, 8'h75}),
        .EXT_MASK    (5'b01111),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .key_held        (key_held),
        .key_press       (key_press),
        .key_release     (key_release),
        .any_held        (any_held),
        .unmapped        (unmapped)
    );

    // Clock / reset
    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference model state
    logic [7:0]    kc [NK] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29};
    bit            extReq [NK] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]    pend [$];
    logic [NK-1:0] mHeld = '0;
    logic [NK-1:0] mPress = '0;
    logic [NK-1:0] mRel = '0;
    logic          mUnm = 1'b0;
    int            rptKey = -1;
    int            nextFire = 0;
    int            tNow = 0;

    int            nChecks = 0;
    int            nErrors = 0;
    int            pressCnt [NK];
    int            relCnt = 0;
    int            unmCnt = 0;

    typedef struct packed {
        logic [1:0]    n;
        logic [7:0]    b0;
        logic [7:0]    b1;
        logic [7:0]    b2;
        logic [NK-1:0] held;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic          unm;
    } vec_t;
    vec_t vecs [15];

    logic [7:0] pauseSeq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tNow);
        end
    endtask

    function automatic bit isFiller(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) ||
               (b == 8'hEE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // Predicts the outputs that follow the upcoming clock edge.
    task automatic modelStep();
        bit         isMake, isBrk, ext, hit;
        logic [7:0] code;
        int         newKey;
        isMake = 0; isBrk = 0; ext = 0; hit = 0; code = 8'h00; newKey = -1;
        mPress = '0; mRel = '0; mUnm = 1'b0;
        if (reset) begin
            mHeld = '0;
            pend.delete();
            rptKey = -1;
            return;
        end
        if (received_data_en) begin
            pend.push_back(received_data);
            if (pend[0] == 8'hE1) begin
                if (pend.size() == 8) pend.delete();
            end else if (pend.size() == 1) begin
                if (pend[0] != 8'hE0 && pend[0] != 8'hF0) begin
                    if (!isFiller(pend[0])) begin
                        isMake = 1; code = pend[0];
                    end
                    pend.delete();
                end
            end else if (pend.size() == 2) begin
                if (!(pend[0] == 8'hE0 && pend[1] == 8'hF0)) begin
                    if (pend[0] == 8'hE0) begin
                        isMake = 1; ext = 1;
                    end else begin
                        isBrk = 1;
                    end
                    code = pend[1];
                    pend.delete();
                end
            end else begin
                isBrk = 1; ext = 1; code = pend[2];
                pend.delete();
            end
        end
        for (int i = 0; i < NK; i++) begin
            if (code == kc[i] && ext == extReq[i]) begin
                if (isMake) begin
                    hit = 1;
                    if (!mHeld[i]) begin
                        mHeld[i] = 1'b1; mPress[i] = 1'b1;
                        if (newKey < 0) newKey = i;
                    end
                end else if (isBrk && mHeld[i]) begin
                    mHeld[i] = 1'b0; mRel[i] = 1'b1;
                    if (i == rptKey) rptKey = -1;
                end
            end
        end
        if (isMake && !hit) mUnm = 1'b1;
        if (newKey >= 0) begin
            rptKey = newKey;
            nextFire = tNow + 20;
        end else if (rptKey >= 0 && tNow == nextFire) begin
            mPress[rptKey] = 1'b1;
            nextFire = tNow + 5;
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge CLOCK_50);
        #1;
        check("held", key_held, mHeld);
        check("press", key_press, mPress);
        check("release", key_release, mRel);
        check("unmapped", unmapped, mUnm);
        check("any_held", any_held, |mHeld);
        for (int k = 0; k < NK; k++) if (key_press[k]) pressCnt[k]++;
        if (key_release != '0) relCnt++;
        if (unmapped) unmCnt++;
        tNow++;
    endtask

    // Driver tasks
    task automatic sendByte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        tick();
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idleUntil(input int t);
        while (tNow < t) tick();
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int         t0;
        int         m;
        int         r;
        int         psum;
        logic [7:0] b;
        int         got [$];
        int         expQ [$];

        foreach (pressCnt[k]) pressCnt[k] = 0;

        vecs[0]  = '{2'd2, 8'hE0, 8'h75, 8'h00, 5'b00001, 5'b00001, 5'b00000, 1'b0};
        vecs[1]  = '{2'd3, 8'hE0, 8'hF0, 8'h75, 5'b00000, 5'b00000, 5'b00001, 1'b0};
        vecs[2]  = '{2'd1, 8'h75, 8'h00, 8'h00, 5'b00000, 5'b00000, 5'b00000, 1'b1};
        vecs[3]  = '{2'd1, 8'h29, 8'h00, 8'h00, 5'b10000, 5'b10000, 5'b00000, 1'b0};
        vecs[4]  = '{2'd2, 8'hF0, 8'h29, 8'h00, 5'b00000, 5'b00000, 5'b10000, 1'b0};
        vecs[5]  = '{2'd1, 8'hAA, 8'h00, 8'h00, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[6]  = '{2'd1, 8'hFA, 8'h00, 8'h00, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[7]  = '{2'd2, 8'hF0, 8'hF0, 8'h00, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[8]  = '{2'd2, 8'hE0, 8'hE0, 8'h00, 5'b00000, 5'b00000, 5'b00000, 1'b1};
        vecs[9]  = '{2'd2, 8'hE0, 8'h74, 8'h00, 5'b01000, 5'b01000, 5'b00000, 1'b0};
        vecs[10] = '{2'd2, 8'hE0, 8'h74, 8'h00, 5'b01000, 5'b00000, 5'b00000, 1'b0};
        vecs[11] = '{2'd2, 8'hF0, 8'h74, 8'h00, 5'b01000, 5'b00000, 5'b00000, 1'b0};
        vecs[12] = '{2'd3, 8'hE0, 8'hF0, 8'h74, 5'b00000, 5'b00000, 5'b01000, 1'b0};
        vecs[13] = '{2'd3, 8'hE0, 8'hF0, 8'h72, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vecs[14] = '{2'd1, 8'h6B, 8'h00, 8'h00, 5'b00000, 5'b00000, 5'b00000, 1'b1};

        // Reset state
        idle(2);
        check("reset held", key_held, 5'b00000);
        check("reset press", key_press, 5'b00000);
        check("reset release", key_release, 5'b00000);
        check("reset any_held", any_held, 1'b0);
        check("reset unmapped", unmapped, 1'b0);
        reset = 1'b0;
        idle(1);

        // Table-driven vectors
        for (int v = 0; v < 15; v++) begin
            sendByte(vecs[v].b0);
            if (vecs[v].n >= 2) sendByte(vecs[v].b1);
            if (vecs[v].n >= 3) sendByte(vecs[v].b2);
            check($sformatf("vec%0d held", v), key_held, vecs[v].held);
            check($sformatf("vec%0d press", v), key_press, vecs[v].press);
            check($sformatf("vec%0d release", v), key_release, vecs[v].rel);
            check($sformatf("vec%0d unmapped", v), unmapped, vecs[v].unm);
            check($sformatf("vec%0d any_held", v), any_held, |vecs[v].held);
            idle(1);
        end

        // Repeat schedule for down, with a typematic resend at cycle 23
        sendByte(8'hE0);
        sendByte(8'h72);
        t0 = tNow - 1;
        got.delete();
        if (key_press[1]) got.push_back(tNow - t0);
        while (tNow - t0 < 33) begin
            if (tNow - t0 == 22) sendByte(8'hE0);
            else if (tNow - t0 == 23) sendByte(8'h72);
            else tick();
            if (key_press[1]) got.push_back(tNow - t0);
        end
        expQ = '{1, 21, 26, 31};
        check("rpt pulse count", got.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < got.size(); i++)
            check($sformatf("rpt pulse %0d time", i), got[i], expQ[i]);
        // Break lands on the tick of the next expiry: release only.
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h72);
        check("break on expiry press", key_press, 5'b00000);
        check("break on expiry release", key_release, 5'b00010);
        idle(8);
        check("no repeat after break", key_press, 5'b00000);

        // Retarget from up to left, release up, make/expiry collision
        sendByte(8'hE0);
        sendByte(8'h75);
        idle(3);
        sendByte(8'hE0);
        sendByte(8'h6B);
        m = tNow - 1;
        foreach (pressCnt[k]) pressCnt[k] = 0;
        idleUntil(m + 10);
        sendByte(8'hE0);
        sendByte(8'hF0);
        sendByte(8'h75);
        check("up release", key_release, 5'b00001);
        check("held after up release", key_held, 5'b00100);
        idleUntil(m + 24);
        sendByte(8'hE0);
        sendByte(8'h74);
        check("collision press", key_press, 5'b01000);
        check("up repeats", pressCnt[0], 0);
        check("left repeats", pressCnt[2], 1);
        idle(2);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h6B);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
        idle(2);

        // Pause sequence produces nothing, then right decodes normally
        foreach (pressCnt[k]) pressCnt[k] = 0;
        relCnt = 0;
        unmCnt = 0;
        for (int i = 0; i < 8; i++) sendByte(pauseSeq[i]);
        psum = 0;
        foreach (pressCnt[k]) psum += pressCnt[k];
        check("pause presses", psum, 0);
        check("pause releases", relCnt, 0);
        check("pause unmapped", unmCnt, 0);
        check("pause held", key_held, 5'b00000);
        sendByte(8'hE0);
        sendByte(8'h74);
        check("right after pause", key_press, 5'b01000);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
        idle(1);

        // Reset mid-sequence and while a key is held
        sendByte(8'hE0);
        pulseReset();
        sendByte(8'h75);
        check("unmapped after reset", unmapped, 1'b1);
        check("held after reset", key_held, 5'b00000);
        sendByte(8'hE0);
        sendByte(8'h72);
        check("down held", key_held, 5'b00010);
        pulseReset();
        check("reset clears held", key_held, 5'b00000);
        check("reset no release", key_release, 5'b00000);
        check("reset any_held", any_held, 1'b0);
        idle(1);

        // Randomized byte stream against the model
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 35)      b = kc[$urandom_range(0, NK - 1)];
            else if (r < 55) b = 8'hE0;
            else if (r < 70) b = 8'hF0;
            else if (r < 73) b = 8'hE1;
            else if (r < 78) b = 8'hAA;
            else             b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) pulseReset();
            sendByte(b);
            if ($urandom_range(0, 19) == 0) idle(25);
            else idle($urandom_range(0, 3));
        end
        idle(40);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
